// File: rtl/menu_ctrl.sv
// menu_ctrl: in-game menu controller and video overlay.
// Decodes ASCII keys into menu navigation and game start/pause control, and
// draws the menu panel, cursor row and value bars over the incoming video.
module menu_ctrl #(
  parameter int                          NUM_ITEMS    = 4,
  parameter int                          VAL_W        = 4,
  parameter logic [NUM_ITEMS*VAL_W-1:0]  INIT_VALUES  = '0,
  parameter int                          KEY_HOLDOFF  = 4,
  parameter int                          PIPE_DEL     = 4,
  parameter int                          MENU_X       = 448,
  parameter int                          MENU_Y       = 256,
  parameter int                          MENU_W       = 128,
  parameter int                          ROW_H        = 16,
  parameter int                          BAR_SCALE    = 8,
  parameter logic [11:0]                 MENU_COLOR   = 12'h555,
  parameter logic [11:0]                 CURSOR_COLOR = 12'h888,
  parameter logic [11:0]                 BAR_COLOR    = 12'h0f0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   key,
  input  logic [15:0]                  vcount_in,
  input  logic [15:0]                  hcount_in,
  input  logic                         vsync_in,
  input  logic                         hsync_in,
  input  logic [11:0]                  rgb_in,
  output logic [15:0]                  vcount_out,
  output logic [15:0]                  hcount_out,
  output logic                         vsync_out,
  output logic                         hsync_out,
  output logic [11:0]                  rgb_out,
  output logic                         menu_active,
  output logic                         game_start,
  output logic [3:0]                   cursor,
  output logic [NUM_ITEMS*VAL_W-1:0]   item_values
);

  localparam logic [7:0] KEY_ESC   = 8'h1b;
  localparam logic [7:0] KEY_ENTER = 8'h0d;
  localparam logic [7:0] KEY_UP    = 8'h77;
  localparam logic [7:0] KEY_DOWN  = 8'h73;
  localparam logic [7:0] KEY_INC   = 8'h64;
  localparam logic [7:0] KEY_DEC   = 8'h61;

  localparam int            HW        = $clog2(KEY_HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(KEY_HOLDOFF);
  localparam logic [3:0]    LAST_ITEM = 4'(NUM_ITEMS - 1);

  localparam logic [31:0] PANEL_X0 = 32'(MENU_X);
  localparam logic [31:0] PANEL_X1 = 32'(MENU_X + MENU_W);
  localparam logic [31:0] PANEL_Y0 = 32'(MENU_Y);
  localparam logic [31:0] PANEL_Y1 = 32'(MENU_Y + NUM_ITEMS * ROW_H);
  localparam logic [31:0] ROW_LEN  = 32'(ROW_H);
  localparam logic [31:0] BAR_MUL  = 32'(BAR_SCALE);

  typedef enum logic {CLOSED, OPEN} state_t;

  state_t                       state_q, state_d;
  logic [3:0]                   cursor_q, cursor_d;
  logic [NUM_ITEMS*VAL_W-1:0]   items_q, items_d;
  logic                         start_q, start_d;
  logic [HW-1:0]                holdoff_q, holdoff_d;
  logic [7:0]                   keyPrev_q;
  logic                         keyAccept;

  logic [31:0]                  hc32, vc32, hOff, rowIdx, barLen;
  logic [VAL_W-1:0]             rowVal;
  logic                         inPanel;
  logic [11:0]                  rgbOverlay;

  logic [15:0]                  vcPipe_q [PIPE_DEL];
  logic [15:0]                  hcPipe_q [PIPE_DEL];
  logic                         vsPipe_q [PIPE_DEL];
  logic                         hsPipe_q [PIPE_DEL];
  logic [11:0]                  rgbPipe_q [PIPE_DEL];

  // A key counts only on a fresh press outside the holdoff window.
  assign keyAccept = (key != 8'h00) && (key != keyPrev_q) && (holdoff_q == '0);

  // Next-state logic: menu FSM, cursor/value edits, start pulse and holdoff.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    items_d   = items_q;
    start_d   = 1'b0;
    holdoff_d = (holdoff_q != '0) ? holdoff_q - HW'(1) : '0;
    if (keyAccept) begin
      holdoff_d = HOLD_LOAD;
      case (state_q)
        CLOSED: begin
          if (key == KEY_ESC) begin
            state_d = OPEN;
          end else if (key == KEY_ENTER) begin
            start_d = 1'b1;
          end
        end
        OPEN: begin
          case (key)
            KEY_ESC:  state_d  = CLOSED;
            KEY_UP:   cursor_d = (cursor_q == 4'd0) ? LAST_ITEM : cursor_q - 4'd1;
            KEY_DOWN: cursor_d = (cursor_q == LAST_ITEM) ? 4'd0 : cursor_q + 4'd1;
            KEY_INC: begin
              for (int i = 0; i < NUM_ITEMS; i++) begin
                if (cursor_q == 4'(i)) begin
                  items_d[i*VAL_W +: VAL_W] = items_q[i*VAL_W +: VAL_W] + VAL_W'(1);
                end
              end
            end
            KEY_DEC: begin
              for (int i = 0; i < NUM_ITEMS; i++) begin
                if (cursor_q == 4'(i)) begin
                  items_d[i*VAL_W +: VAL_W] = items_q[i*VAL_W +: VAL_W] - VAL_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
        default: state_d = CLOSED;
      endcase
    end
  end

  // Control registers, including the key history used for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CLOSED;
      cursor_q  <= 4'd0;
      items_q   <= INIT_VALUES;
      start_q   <= 1'b0;
      holdoff_q <= '0;
      keyPrev_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      items_q   <= items_d;
      start_q   <= start_d;
      holdoff_q <= holdoff_d;
      keyPrev_q <= key;
    end
  end

  // Overlay colour for the pixel entering the pipe, using the current menu state.
  always_comb begin
    hc32    = {16'h0000, hcount_in};
    vc32    = {16'h0000, vcount_in};
    hOff    = hc32 - PANEL_X0;
    rowIdx  = (vc32 - PANEL_Y0) / ROW_LEN;
    rowVal  = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rowIdx == 32'(i)) begin
        rowVal = items_q[i*VAL_W +: VAL_W];
      end
    end
    barLen  = 32'(rowVal) * BAR_MUL;
    inPanel = (state_q == OPEN) &&
              (hc32 >= PANEL_X0) && (hc32 < PANEL_X1) &&
              (vc32 >= PANEL_Y0) && (vc32 < PANEL_Y1);
    rgbOverlay = rgb_in;
    if (inPanel) begin
      if (hOff < barLen) begin
        rgbOverlay = BAR_COLOR;
      end else if (rowIdx == {28'h0000000, cursor_q}) begin
        rgbOverlay = CURSOR_COLOR;
      end else begin
        rgbOverlay = MENU_COLOR;
      end
    end
  end

  // Shared delay line keeping counters, syncs and pixel colour aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_DEL; i++) begin
        vcPipe_q[i]  <= 16'h0000;
        hcPipe_q[i]  <= 16'h0000;
        vsPipe_q[i]  <= 1'b0;
        hsPipe_q[i]  <= 1'b0;
        rgbPipe_q[i] <= 12'h000;
      end
    end else begin
      vcPipe_q[0]  <= vcount_in;
      hcPipe_q[0]  <= hcount_in;
      vsPipe_q[0]  <= vsync_in;
      hsPipe_q[0]  <= hsync_in;
      rgbPipe_q[0] <= rgbOverlay;
      for (int i = 1; i < PIPE_DEL; i++) begin
        vcPipe_q[i]  <= vcPipe_q[i-1];
        hcPipe_q[i]  <= hcPipe_q[i-1];
        vsPipe_q[i]  <= vsPipe_q[i-1];
        hsPipe_q[i]  <= hsPipe_q[i-1];
        rgbPipe_q[i] <= rgbPipe_q[i-1];
      end
    end
  end

  assign vcount_out  = vcPipe_q[PIPE_DEL-1];
  assign hcount_out  = hcPipe_q[PIPE_DEL-1];
  assign vsync_out   = vsPipe_q[PIPE_DEL-1];
  assign hsync_out   = hsPipe_q[PIPE_DEL-1];
  assign rgb_out     = rgbPipe_q[PIPE_DEL-1];
  assign menu_active = (state_q == OPEN);
  assign game_start  = start_q;
  assign cursor      = cursor_q;
  assign item_values = items_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: directed self-checking bench for menu_ctrl.
module tb_menu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key;
  logic [15:0] vcount_in, hcount_in;
  logic        vsync_in, hsync_in;
  logic [11:0] rgb_in;
  logic [15:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out;
  logic [11:0] rgb_out;
  logic        menu_active, game_start;
  logic [3:0]  cursor;
  logic [15:0] item_values;

  typedef struct {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_t;

  pix_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   pixN  = 0;
  int   pulses;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  menu_ctrl #(.INIT_VALUES(16'h4321)) dut (
    .clk(clk), .rst(rst), .key(key),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .rgb_in(rgb_in),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .rgb_out(rgb_out),
    .menu_active(menu_active), .game_start(game_start),
    .cursor(cursor), .item_values(item_values)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] k);
    key = k;
    step(1);
    key = 8'h00;
    step(5);
  endtask

  task automatic beginRun();
    expQ.delete();
  endtask

  task automatic applyPixel(input logic [15:0] h, input logic [15:0] v,
                            input logic [11:0] rgbIn, input logic [11:0] expRgb);
    pix_t p;
    logic [31:0] n;
    n = 32'(pixN);
    hcount_in = h;
    vcount_in = v;
    hsync_in  = n[0];
    vsync_in  = n[1];
    rgb_in    = rgbIn;
    p.h = h; p.v = v; p.hs = n[0]; p.vs = n[1]; p.rgb = expRgb;
    expQ.push_back(p);
    pixN++;
    step(1);
    if (expQ.size() == 4) begin
      p = expQ.pop_front();
      checkOutput("pipe_rgb",    32'(rgb_out),    32'(p.rgb));
      checkOutput("pipe_hcount", 32'(hcount_out), 32'(p.h));
      checkOutput("pipe_vcount", 32'(vcount_out), 32'(p.v));
      checkOutput("pipe_hsync",  32'(hsync_out),  32'(p.hs));
      checkOutput("pipe_vsync",  32'(vsync_out),  32'(p.vs));
    end
  endtask

  initial begin
    rst = 1'b0; key = 8'h1b;
    hcount_in = 16'd449; vcount_in = 16'd257;
    hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 12'hfff;
    step(3);
    checkOutput("rst_active",  32'(menu_active), 32'd0);
    checkOutput("rst_cursor",  32'(cursor),      32'd0);
    checkOutput("rst_items",   32'(item_values), 32'h4321);
    checkOutput("rst_start",   32'(game_start),  32'd0);
    checkOutput("rst_rgb",     32'(rgb_out),     32'd0);
    checkOutput("rst_hcount",  32'(hcount_out),  32'd0);
    checkOutput("rst_hsync",   32'(hsync_out),   32'd0);

    rst = 1'b1; key = 8'h00;
    $display("[TB] reset released, checking pipeline latency");
    beginRun();
    for (int n = 0; n < 8; n++) begin
      applyPixel(16'(100 + n), 16'(40 + 2 * n), 12'(12'h123 + 7 * n), 12'(12'h123 + 7 * n));
    end
    checkOutput("post_rst_active", 32'(menu_active), 32'd0);

    key = 8'h0d;
    step(1);
    checkOutput("start_rise", 32'(game_start), 32'd1);
    step(1);
    checkOutput("start_fall", 32'(game_start), 32'd0);
    pulses = 0;
    for (int n = 0; n < 18; n++) begin
      step(1);
      if (game_start) pulses++;
    end
    checkOutput("start_extra", 32'(pulses), 32'd0);
    checkOutput("start_closed", 32'(menu_active), 32'd0);
    key = 8'h00;
    step(5);

    applyStimulus(8'h1b);
    checkOutput("open_active", 32'(menu_active), 32'd1);
    key = 8'h0d;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      step(1);
      if (game_start) pulses++;
    end
    checkOutput("open_nostart", 32'(pulses), 32'd0);
    checkOutput("open_enter_stays", 32'(menu_active), 32'd1);
    key = 8'h00;
    step(5);

    $display("[TB] cursor and value wrap");
    applyStimulus(8'h77);
    checkOutput("cur_wrap_up", 32'(cursor), 32'd3);
    applyStimulus(8'h73);
    checkOutput("cur_wrap_down", 32'(cursor), 32'd0);
    applyStimulus(8'h73);
    applyStimulus(8'h73);
    applyStimulus(8'h73);
    checkOutput("cur_four_down", 32'(cursor), 32'd3);
    applyStimulus(8'h73);
    applyStimulus(8'h73);
    checkOutput("cur_at_1", 32'(cursor), 32'd1);
    applyStimulus(8'h61);
    checkOutput("val_dec", 32'(item_values), 32'h4311);
    applyStimulus(8'h61);
    applyStimulus(8'h61);
    checkOutput("val_wrap_down", 32'(item_values), 32'h43f1);
    applyStimulus(8'h64);
    checkOutput("val_wrap_up", 32'(item_values), 32'h4301);
    applyStimulus(8'h61);
    checkOutput("val_back_15", 32'(item_values), 32'h43f1);

    $display("[TB] key holdoff");
    key = 8'h64;
    step(1);
    checkOutput("hold_d_taken", 32'(item_values), 32'h4301);
    key = 8'h73;
    step(6);
    checkOutput("hold_s_lost", 32'(cursor), 32'd1);
    key = 8'h00;
    step(2);
    applyStimulus(8'h73);
    checkOutput("hold_s_after", 32'(cursor), 32'd2);
    key = 8'h77;
    step(1);
    checkOutput("hold_w_taken", 32'(cursor), 32'd1);
    key = 8'h00;
    step(3);
    key = 8'h73;
    step(1);
    checkOutput("hold_edge_reject", 32'(cursor), 32'd1);
    key = 8'h00;
    step(1);
    key = 8'h77;
    step(1);
    checkOutput("hold_w2_taken", 32'(cursor), 32'd0);
    key = 8'h00;
    step(4);
    key = 8'h73;
    step(1);
    checkOutput("hold_edge_accept", 32'(cursor), 32'd1);
    key = 8'h00;
    step(5);
    applyStimulus(8'h77);
    applyStimulus(8'h64);
    checkOutput("ovl_setup_cursor", 32'(cursor), 32'd0);
    checkOutput("ovl_setup_items", 32'(item_values), 32'h4302);

    $display("[TB] overlay pixels");
    beginRun();
    applyPixel(16'd449, 16'd257, 12'habc, 12'h0f0);
    applyPixel(16'd470, 16'd257, 12'habd, 12'h888);
    applyPixel(16'd470, 16'd280, 12'habe, 12'h555);
    applyPixel(16'd447, 16'd257, 12'habf, 12'habf);
    applyPixel(16'd463, 16'd257, 12'h101, 12'h0f0);
    applyPixel(16'd464, 16'd257, 12'h102, 12'h888);
    applyPixel(16'd575, 16'd257, 12'h103, 12'h888);
    applyPixel(16'd576, 16'd257, 12'h104, 12'h104);
    applyPixel(16'd449, 16'd255, 12'h105, 12'h105);
    applyPixel(16'd449, 16'd319, 12'h106, 12'h0f0);
    applyPixel(16'd449, 16'd320, 12'h107, 12'h107);
    applyPixel(16'd471, 16'd290, 12'h108, 12'h0f0);
    applyPixel(16'd472, 16'd290, 12'h109, 12'h555);
    applyPixel(16'd575, 16'd300, 12'h10a, 12'h555);
    applyPixel(16'd0, 16'd0, 12'h201, 12'h201);
    applyPixel(16'd0, 16'd0, 12'h202, 12'h202);
    applyPixel(16'd0, 16'd0, 12'h203, 12'h203);

    applyStimulus(8'h1b);
    checkOutput("close_active", 32'(menu_active), 32'd0);
    checkOutput("close_keeps_items", 32'(item_values), 32'h4302);
    beginRun();
    applyPixel(16'd449, 16'd257, 12'h321, 12'h321);
    applyPixel(16'd470, 16'd257, 12'h322, 12'h322);
    applyPixel(16'd0, 16'd0, 12'h301, 12'h301);
    applyPixel(16'd0, 16'd0, 12'h302, 12'h302);
    applyPixel(16'd0, 16'd0, 12'h303, 12'h303);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
